fetch_unit: RTL and testbench

Parametrised instruction-fetch stage for the pipelined RISC-V core. It replaces the single-cycle IF logic (PC register, +4 adder, redirect mux) with a decoupled front end. The front end issues requests to IMEM over a valid/ready handshake and tolerates variable response latency with several requests in flight. Fetched {pc, instr} pairs are buffered in a FIFO that decode drains via its own valid/ready handshake. Branch/jump redirects from EX/MEM flush the buffer, and the unit silently discards stale in-flight responses.

---
 rtl/fetch_unit.sv | 166 ++++++++++++++++
 tb/tb_fetch_unit.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Decoupled instruction-fetch front end: credit-limited IMEM requests, in-order tag tracking,
// and a {pc, instr} fetch buffer drained by decode. Define FETCH_BYPASS_EN for same-cycle bypass.
module fetch_unit #(
    parameter int unsigned      XLEN            = 64,
    parameter int unsigned      ILEN            = 32,
    parameter int unsigned      FIFO_DEPTH      = 4,
    parameter int unsigned      MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0]  RESET_PC        = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [ILEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned TAG_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [XLEN-1:0]  fetch_pc;

    logic [XLEN-1:0]  tag_mem [MAX_OUTSTANDING];
    logic [TAG_W-1:0] tag_wr_ptr;
    logic [TAG_W-1:0] tag_rd_ptr;
    logic [OUT_W-1:0] outstanding;
    logic [OUT_W-1:0] drop;

    logic [XLEN-1:0]  buf_pc    [FIFO_DEPTH];
    logic [ILEN-1:0]  buf_instr [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] fifo_count;

    logic             req_fire;
    logic             rsp_fire;
    logic             rsp_live;
    logic             fifo_empty;
    logic             bypass_avail;
    logic             bypass_take;
    logic             fifo_push;
    logic             fifo_pop;
    logic [XLEN-1:0]  tag_pc;
    logic [CNT_W:0]   credit_used;
    logic             unused_ok;

    function automatic logic [TAG_W-1:0] tag_next(input logic [TAG_W-1:0] p);
        if (p == TAG_W'(MAX_OUTSTANDING - 1)) begin
            return '0;
        end
        return p + TAG_W'(1);
    endfunction

    // Live responses plus buffered entries must always fit, so every response has a slot.
    assign credit_used = {1'b0, fifo_count} + (CNT_W+1)'(outstanding) - (CNT_W+1)'(drop);

    assign imem_req_valid = rst && !redirect_valid
                            && (outstanding < OUT_W'(MAX_OUTSTANDING))
                            && (credit_used < (CNT_W+1)'(FIFO_DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Responses with nothing in flight are protocol violations and are ignored.
    assign rsp_fire   = rst && imem_rsp_valid && (outstanding != '0);
    assign rsp_live   = rsp_fire && (drop == '0) && !redirect_valid;
    assign tag_pc     = tag_mem[tag_rd_ptr];
    assign fifo_empty = (fifo_count == '0);

`ifdef FETCH_BYPASS_EN
    assign bypass_avail = rsp_live && fifo_empty;
`else
    assign bypass_avail = 1'b0;
`endif

    assign bypass_take = bypass_avail && if_ready;
    assign fifo_push   = rsp_live && !bypass_take;
    assign fifo_pop    = !fifo_empty && if_ready;
    assign if_valid    = !fifo_empty || bypass_avail;

    always_comb begin
        if_pc    = '0;
        if_instr = '0;
        if (!fifo_empty) begin
            if_pc    = buf_pc[rd_ptr];
            if_instr = buf_instr[rd_ptr];
        end else if (bypass_avail) begin
            if_pc    = tag_pc;
            if_instr = imem_rsp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            tag_wr_ptr  <= '0;
            tag_rd_ptr  <= '0;
            outstanding <= '0;
            drop        <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            fifo_count  <= '0;
        end else begin
            if (redirect_valid) begin
                fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
            end else if (req_fire) begin
                fetch_pc <= fetch_pc + XLEN'(4);
            end

            if (req_fire) begin
                tag_wr_ptr <= tag_next(tag_wr_ptr);
            end
            if (rsp_fire) begin
                tag_rd_ptr <= tag_next(tag_rd_ptr);
            end
            outstanding <= outstanding + OUT_W'(req_fire) - OUT_W'(rsp_fire);

            // Everything still in flight at a redirect belongs to the old path.
            if (redirect_valid) begin
                drop <= outstanding - OUT_W'(rsp_fire);
            end else if (rsp_fire && (drop != '0)) begin
                drop <= drop - OUT_W'(1);
            end

            if (redirect_valid) begin
                rd_ptr     <= '0;
                wr_ptr     <= '0;
                fifo_count <= '0;
            end else begin
                if (fifo_push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (fifo_pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                fifo_count <= fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) begin
            tag_mem[tag_wr_ptr] <= fetch_pc;
        end
        if (fifo_push) begin
            buf_pc[wr_ptr]    <= tag_pc;
            buf_instr[wr_ptr] <= imem_rsp_data;
        end
    end

    assign unused_ok = ^redirect_pc[1:0];

    a_fifo_bound: assert property (@(posedge clk) disable iff (!rst)
        fifo_count <= CNT_W'(FIFO_DEPTH));
    a_drop_bound: assert property (@(posedge clk) disable iff (!rst)
        drop <= outstanding);

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a behavioural IMEM with random latency and an in-order
// expected-stream model (restart on reset/redirect) checked by an independent monitor.
module tb_fetch_unit;

    localparam int XLEN  = 64;
    localparam int ILEN  = 32;
    localparam int DEPTH = 4;
    localparam int MAXO  = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [ILEN-1:0] imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            if_valid;
    logic            if_ready;
    logic [ILEN-1:0] if_instr;
    logic [XLEN-1:0] if_pc;

    always #5 clk = ~clk;

    fetch_unit #(
        .XLEN(XLEN), .ILEN(ILEN), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(64'h0)
    ) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc)
    );

    typedef struct { logic [63:0] pc; logic [31:0] instr; } exp_t;
    typedef struct { logic [63:0] addr; int due; } pend_t;

    exp_t        exp_q [$];
    pend_t       pend  [$];
    exp_t        e;
    logic [63:0] model_pc;
    logic [63:0] first_pc;
    bit          seen_pop;
    int          cycle;
    int          lat;
    int          errors;
    int          checks;

    function automatic logic [31:0] instr_of(input logic [63:0] pc);
        if (pc == 64'h8) return 32'h0050_0093;
        return (pc[31:0] * 32'h9E37_79B1) ^ {pc[63:34], 2'b11};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic fail(input string name, input string detail);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, detail);
    endtask

    // Monitor: compares every delivered entry against the head of the expected stream.
    always @(negedge clk) begin
        if (rst) begin
            if (redirect_valid) chk("req_in_redirect", 64'(imem_req_valid), 64'd0);
            if (imem_req_valid) chk("req_addr", imem_req_addr, model_pc);
            if (if_valid && if_ready) begin
                if (exp_q.size() == 0) begin
                    fail("unexpected_pop", $sformatf("got pc %h, expected no entry", if_pc));
                end else begin
                    e = exp_q.pop_front();
                    chk("if_pc", if_pc, e.pc);
                    chk("if_instr", 64'(if_instr), 64'(e.instr));
                end
                if (!seen_pop) begin
                    seen_pop = 1'b1;
                    first_pc = if_pc;
                end
            end
        end
    end

    // One clock: latch what commits at the edge, update the model and IMEM, drive the response.
    task automatic step();
        logic        f_req;
        logic        f_redir;
        logic        f_rst;
        logic [63:0] r_addr;
        logic [63:0] r_pc;
        int          acc_cycle;
        @(negedge clk);
        f_rst   = !rst;
        f_req   = rst && imem_req_valid && imem_req_ready;
        f_redir = rst && redirect_valid;
        r_addr  = imem_req_addr;
        r_pc    = redirect_pc;
        @(posedge clk);
        acc_cycle = cycle;
        cycle++;
        if (f_rst) begin
            exp_q.delete();
            pend.delete();
            model_pc = 64'h0;
        end else begin
            if (f_req) pend.push_back('{addr: r_addr, due: acc_cycle + lat});
            if (f_redir) begin
                exp_q.delete();
                model_pc = {r_pc[63:2], 2'b00};
            end else if (f_req) begin
                exp_q.push_back('{pc: model_pc, instr: instr_of(model_pc)});
                model_pc = model_pc + 64'd4;
            end
        end
        #1;
        if (rst && pend.size() > 0 && pend[0].due <= cycle) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instr_of(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            imem_rsp_valid = !rst && 1'($urandom);
            imem_rsp_data  = $urandom;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        redirect_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at 1ms, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  acc;
        bit  found;
        rst = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b0;
        lat = 1; cycle = 0; model_pc = 64'h0; errors = 0; checks = 0; seen_pop = 1'b0; first_pc = '0;

        // Reset held with random inputs
        step();
        for (int i = 0; i < 3; i++) begin
            imem_req_ready = 1'($urandom); if_ready = 1'($urandom);
            redirect_valid = 1'($urandom); redirect_pc = {$urandom, $urandom};
            #1;
            chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
            chk("rst_if_valid", 64'(if_valid), 64'd0);
            chk("rst_addr", imem_req_addr, 64'h0);
            chk("rst_if_pc", if_pc, 64'h0);
            chk("rst_if_instr", 64'(if_instr), 64'd0);
            step();
        end
        rst = 1'b1; redirect_valid = 1'b0; imem_req_ready = 1'b1; if_ready = 1'b1; lat = 1;
        #1;
        chk("rel_req_valid", 64'(imem_req_valid), 64'd1);
        chk("rel_addr", imem_req_addr, 64'h0);

        // Streaming, 1-cycle IMEM latency
        for (int i = 0; i < 30; i++) begin
`ifdef FETCH_BYPASS_EN
            if (i == 1) chk("bypass_first_valid", 64'(if_valid), 64'd1);
            if (i == 3) begin
                chk("bypass_valid", 64'(if_valid), 64'd1);
                chk("bypass_instr", 64'(if_instr), 64'h0050_0093);
                chk("bypass_pc", if_pc, 64'h8);
            end
            if (i == 4) chk("bypass_fifo_count", 64'(dut.fifo_count), 64'd0);
`else
            if (i == 1) chk("lat_rsp_cycle_valid", 64'(if_valid), 64'd0);
            if (i == 2) begin
                chk("lat_next_valid", 64'(if_valid), 64'd1);
                chk("lat_next_pc", if_pc, 64'h0);
            end
`endif
            if (i >= 4) chk("no_bubble", 64'(if_valid), 64'd1);
            step();
            #1;
        end

        // Backpressure: decode stalled
        do_reset();
        if_ready = 1'b0; imem_req_ready = 1'b1; lat = 1; acc = 0;
        for (int i = 0; i < 14; i++) begin
            if (imem_req_valid && imem_req_ready) acc++;
            step();
            #1;
        end
        chk("bp_accepted", 64'(acc), 64'(DEPTH));
        chk("bp_req_stall", 64'(imem_req_valid), 64'd0);
        chk("bp_if_valid", 64'(if_valid), 64'd1);
        if_ready = 1'b1;
        run(15);

        // Redirect with two requests in flight and a non-empty buffer
        do_reset();
        if_ready = 1'b0; imem_req_ready = 1'b1; lat = 4; found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (pend.size() == 2 && !imem_rsp_valid && if_valid) begin
                found = 1'b1;
                break;
            end
            step();
            #1;
        end
        if (!found) fail("redir_setup", "got no 2-outstanding state in 60 cycles, expected one");
        redirect_valid = 1'b1; redirect_pc = 64'h103;
        #1;
        chk("redir_req_valid", 64'(imem_req_valid), 64'd0);
        step();
        redirect_valid = 1'b0; if_ready = 1'b1; seen_pop = 1'b0;
        #1;
        chk("redir_fifo_cleared", 64'(if_valid), 64'd0);
        chk("redir_addr", imem_req_addr, 64'h100);
        run(25);
        chk("redir_seen_pop", 64'(seen_pop), 64'd1);
        chk("redir_first_pc", first_pc, 64'h100);

        // Redirect coinciding with a response and a pop
        do_reset();
        if_ready = 1'b0; imem_req_ready = 1'b1; lat = 3; found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (imem_rsp_valid && if_valid && pend.size() >= 1) begin
                found = 1'b1;
                break;
            end
            step();
            #1;
        end
        if (!found) fail("same_setup", "got no rsp+pop+inflight state in 60 cycles, expected one");
        if_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h2000;
        #1;
        chk("same_req_valid", 64'(imem_req_valid), 64'd0);
        chk("same_pop_pc", if_pc, 64'h0);
        step();
        redirect_valid = 1'b0; seen_pop = 1'b0;
        #1;
        run(25);
        chk("same_first_pc", first_pc, 64'h2000);

        // PC wrap at the top of the address space
        imem_req_ready = 1'b1; if_ready = 1'b1; lat = 1;
        redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFA;
        step();
        redirect_valid = 1'b0; seen_pop = 1'b0;
        #1;
        run(20);
        chk("wrap_first_pc", first_pc, 64'hFFFF_FFFF_FFFF_FFF8);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            imem_req_ready = ($urandom_range(0, 3) != 0);
            if_ready       = ($urandom_range(0, 2) != 0);
            lat            = $urandom_range(1, 5);
            redirect_valid = ($urandom_range(0, 24) == 0);
            redirect_pc    = {$urandom, $urandom};
            rst            = ($urandom_range(0, 399) != 0);
            step();
            #1;
        end
        rst = 1'b1; redirect_valid = 1'b0; if_ready = 1'b1; imem_req_ready = 1'b1;
        run(30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
